// File: rtl/apb_master_mux.sv
// APB master with address decode onto NUM_SLV slave channels (IDLE/SETUP/ACCESS).
// Define APB_MASTER_TIMEOUT_EN to compile in the ACCESS-phase wait timeout.
module apb_master_mux #(
   parameter int          NUM_SLV   = 4,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int          SLV_AW    = 12,
   parameter int          TIMEOUT   = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  transfer,
   input  logic                  write,
   input  logic [31:0]           addr,
   input  logic [31:0]           wdata,
   output logic                  ready,
   output logic [31:0]           rdata,
   output logic                  err,
   output logic [SLV_AW-1:0]     PADDR,
   output logic                  PWRITE,
   output logic                  PENABLE,
   output logic [31:0]           PWDATA,
   output logic [NUM_SLV-1:0]    PSEL,
   input  logic [NUM_SLV*32-1:0] PRDATA,
   input  logic [NUM_SLV-1:0]    PREADY
);

   if (NUM_SLV < 1 || NUM_SLV > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
      $error("apb_master_mux: NUM_SLV must be 1..8 and TIMEOUT 2..255");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t               state;
   logic                 miss_q;
   logic [31:0]          offset;
   logic [31:0]          slot;
   logic                 hit;
   logic                 accept;
   logic [NUM_SLV-1:0]   dec_onehot;
   logic                 pready_sel;
   logic [31:0]          prdata_sel;
   logic                 done_ok;
   logic                 timeout_hit;

   // Unsigned subtract; addresses below the window are rejected by the >= test, so no wrap.
   assign offset = addr - BASE_ADDR;
   assign slot   = offset >> SLV_AW;
   assign hit    = (addr >= BASE_ADDR) && (slot < 32'(NUM_SLV));
   // A transfer arriving with the miss-completion pulse is dropped, not queued.
   assign accept = (state == IDLE) && transfer && !miss_q;

   always_comb begin
      dec_onehot = '0;
      pready_sel = 1'b0;
      prdata_sel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         dec_onehot[i] = (slot == 32'(i));
         pready_sel    = pready_sel | (PSEL[i] & PREADY[i]);
         if (PSEL[i]) prdata_sel = PRDATA[32*i +: 32];
      end
   end

   assign done_ok = (state == ACCESS) && pready_sel;

`ifdef APB_MASTER_TIMEOUT_EN
   logic [7:0] tcnt;
   // PREADY in the limit cycle takes priority over the timeout.
   assign timeout_hit = (state == ACCESS) && !pready_sel && (tcnt == 8'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // Completion outputs are combinational so a zero-wait slave finishes in its ACCESS cycle.
   assign ready = !PRESET && (miss_q || done_ok || timeout_hit);
   assign err   = !PRESET && (miss_q || timeout_hit);
   assign rdata = (!PRESET && done_ok && !PWRITE) ? prdata_sel : 32'h0;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state   <= IDLE;
         miss_q  <= 1'b0;
         PSEL    <= '0;
         PENABLE <= 1'b0;
         PADDR   <= '0;
         PWRITE  <= 1'b0;
         PWDATA  <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
         tcnt    <= '0;
`endif
      end else begin
         miss_q <= accept && !hit;
         case (state)
            IDLE: begin
               if (accept && hit) begin
                  state  <= SETUP;
                  PSEL   <= dec_onehot;
                  PADDR  <= addr[SLV_AW-1:0];
                  PWRITE <= write;
                  PWDATA <= wdata;
               end
            end
            SETUP: begin
               state   <= ACCESS;
               PENABLE <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
               tcnt    <= '0;
`endif
            end
            ACCESS: begin
               if (done_ok || timeout_hit) begin
                  state   <= IDLE;
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else begin
                  tcnt <= tcnt + 8'd1;
               end
`endif
            end
            default: begin
               state   <= IDLE;
               PSEL    <= '0;
               PENABLE <= 1'b0;
            end
         endcase
      end
   end

endmodule
